// File: rtl/esquema_final.sv
// esquema_final: single-account ATM teller controller (login, timed session, deposit/withdraw).
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   ENABLE                   global enable; 0 freezes all state
//   PIN0..PIN3, COD0..COD4   PIN and account code (bit 0 is LSB)
//   Seleciona                confirm key, acts on rising edge
//   SelecionaOpcoes          0 = deposit, 1 = withdraw
//   VAL1..VAL4, Cin          transaction amount (VAL1 LSB) plus carry-in
//   Cout                     1 = last transaction rejected (overflow/borrow)
//   SALDOecra1..4            balance display (session only)
//   VALecra1..4              registered amount display (session only)
//   Tempo                    remaining session cycles
module esquema_final #(
    parameter logic [4:0] ACC_COD    = 5'b10000,
    parameter logic [3:0] ACC_PIN    = 4'b1001,
    parameter logic [4:0] CANCEL_COD = 5'b11111,
    parameter logic [3:0] INIT_BAL   = 4'd10,
    parameter logic [8:0] TIMEOUT    = 9'd300,
    parameter int         MAX_FAILS  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ENABLE,
    input  logic       PIN0, PIN1, PIN2, PIN3,
    input  logic       COD0, COD1, COD2, COD3, COD4,
    input  logic       Seleciona,
    input  logic       SelecionaOpcoes,
    input  logic       VAL1, VAL2, VAL3, VAL4,
    input  logic       Cin,
    output logic       Cout,
    output logic       SALDOecra1, SALDOecra2, SALDOecra3, SALDOecra4,
    output logic       VALecra1, VALecra2, VALecra3, VALecra4,
    output logic [8:0] Tempo
);
    typedef enum logic [1:0] {IDLE, SESSION, LOCKED} state_t;

    localparam logic [1:0] LAST_FAIL = 2'(MAX_FAILS - 1);

    state_t     r_state, w_state_n;
    logic [3:0] r_bal, w_bal_n;
    logic [1:0] r_fails, w_fails_n;
    logic [8:0] r_tempo, w_tempo_n;
    logic       r_cout, w_cout_n;
    logic       r_sel_q;
    logic [3:0] r_val;

    logic [4:0] w_cod;
    logic [3:0] w_pin, w_val, w_saldo, w_valecra;
    logic [4:0] w_amt, w_sum;
    logic       w_edge;

    assign w_cod  = {COD4, COD3, COD2, COD1, COD0};
    assign w_pin  = {PIN3, PIN2, PIN1, PIN0};
    assign w_val  = {VAL4, VAL3, VAL2, VAL1};
    assign w_amt  = {1'b0, w_val} + {4'b0, Cin};
    assign w_sum  = {1'b0, r_bal} + w_amt;
    assign w_edge = Seleciona & ~r_sel_q;

    always_comb begin
        w_state_n = r_state;
        w_bal_n   = r_bal;
        w_fails_n = r_fails;
        w_tempo_n = r_tempo;
        w_cout_n  = r_cout;
        case (r_state)
            IDLE: if (w_edge) begin
                if (w_cod == ACC_COD && w_pin == ACC_PIN) begin
                    w_state_n = SESSION;
                    w_tempo_n = TIMEOUT;
                    w_fails_n = 2'd0;
                    w_cout_n  = 1'b0;
                end else begin
                    w_fails_n = r_fails + 2'd1;
                    // lockout shows reset-valued outputs, so the flag is cleared too
                    if (r_fails == LAST_FAIL) begin
                        w_state_n = LOCKED;
                        w_cout_n  = 1'b0;
                    end
                end
            end
            SESSION: begin
                if (w_edge && w_cod == CANCEL_COD) begin
                    w_state_n = IDLE;
                    w_tempo_n = 9'd0;
                end else if (w_edge) begin
                    w_tempo_n = TIMEOUT;
                    if (!SelecionaOpcoes) begin
                        w_cout_n = w_sum > 5'd15;
                        w_bal_n  = w_sum > 5'd15 ? r_bal : w_sum[3:0];
                    end else begin
                        w_cout_n = w_amt > {1'b0, r_bal};
                        w_bal_n  = w_amt > {1'b0, r_bal} ? r_bal : r_bal - w_amt[3:0];
                    end
                end else if (r_tempo == 9'd1) begin
                    w_state_n = IDLE;
                    w_tempo_n = 9'd0;
                end else begin
                    w_tempo_n = r_tempo - 9'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_bal   <= INIT_BAL;
            r_fails <= 2'd0;
            r_tempo <= 9'd0;
            r_cout  <= 1'b0;
            r_sel_q <= 1'b0;
            r_val   <= 4'd0;
        end else if (ENABLE) begin
            r_state <= w_state_n;
            r_bal   <= w_bal_n;
            r_fails <= w_fails_n;
            r_tempo <= w_tempo_n;
            r_cout  <= w_cout_n;
            r_sel_q <= Seleciona;
            r_val   <= w_val;
        end
    end

    assign w_saldo   = r_state == SESSION ? r_bal : 4'd0;
    assign w_valecra = r_state == SESSION ? r_val : 4'd0;
    assign {SALDOecra4, SALDOecra3, SALDOecra2, SALDOecra1} = w_saldo;
    assign {VALecra4, VALecra3, VALecra2, VALecra1}         = w_valecra;
    assign Cout  = r_cout;
    assign Tempo = r_tempo;
endmodule

// File: tb/tb_esquema_final.sv
// tb_esquema_final: directed plus randomized checks of esquema_final against a behavioural model.
module tb_esquema_final;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1, sel = 1'b0, op = 1'b0, cin = 1'b0;
    logic [4:0] cod = 5'd0;
    logic [3:0] pin = 4'd0, val = 4'd0;
    logic       cout;
    logic [3:0] saldo, valecra;
    logic [8:0] tempo;

    int checks = 0, errors = 0;

    // behavioural model: session = 0 idle, 1 in session, 2 locked out
    int m_mode, m_bal, m_fails, m_tempo, m_cout, m_val_q, m_sel_q;

    esquema_final dut (
        .clk(clk), .reset(reset), .ENABLE(en),
        .PIN0(pin[0]), .PIN1(pin[1]), .PIN2(pin[2]), .PIN3(pin[3]),
        .COD0(cod[0]), .COD1(cod[1]), .COD2(cod[2]), .COD3(cod[3]), .COD4(cod[4]),
        .Seleciona(sel), .SelecionaOpcoes(op),
        .VAL1(val[0]), .VAL2(val[1]), .VAL3(val[2]), .VAL4(val[3]),
        .Cin(cin), .Cout(cout),
        .SALDOecra1(saldo[0]), .SALDOecra2(saldo[1]), .SALDOecra3(saldo[2]), .SALDOecra4(saldo[3]),
        .VALecra1(valecra[0]), .VALecra2(valecra[1]), .VALecra3(valecra[2]), .VALecra4(valecra[3]),
        .Tempo(tempo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_bal = 10; m_fails = 0; m_tempo = 0; m_cout = 0; m_val_q = 0; m_sel_q = 0;
    endtask

    task automatic model_step();
        int amt;
        bit edge_now;
        if (!en) return;
        edge_now = sel && !m_sel_q;
        amt = int'(val) + int'(cin);
        if (m_mode == 0 && edge_now) begin
            if (cod == 5'd16 && pin == 4'd9) begin
                m_mode = 1; m_tempo = 300; m_fails = 0; m_cout = 0;
            end else begin
                m_fails++;
                if (m_fails == 3) begin m_mode = 2; m_cout = 0; end
            end
        end else if (m_mode == 1) begin
            if (edge_now && cod == 5'd31) begin
                m_mode = 0; m_tempo = 0;
            end else if (edge_now) begin
                m_tempo = 300;
                if (!op) begin
                    if (m_bal + amt <= 15) begin m_bal += amt; m_cout = 0; end
                    else m_cout = 1;
                end else begin
                    if (amt <= m_bal) begin m_bal -= amt; m_cout = 0; end
                    else m_cout = 1;
                end
            end else if (m_tempo == 1) begin
                m_mode = 0; m_tempo = 0;
            end else m_tempo--;
        end
        m_val_q = int'(val);
        m_sel_q = int'(sel);
    endtask

    task automatic check_all();
        check("tempo", int'(tempo), m_tempo);
        check("cout", int'(cout), m_cout);
        check("saldo", int'(saldo), m_mode == 1 ? m_bal : 0);
        check("valecra", int'(valecra), m_mode == 1 ? m_val_q : 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic press(input logic [4:0] c, input logic [3:0] p);
        cod = c; pin = p; sel = 1'b1;
        cyc();
        sel = 1'b0;
        cyc();
    endtask

    task automatic txn(input logic o, input logic [3:0] v, input logic c);
        op = o; val = v; cin = c; cod = 5'd0; sel = 1'b1;
        cyc();
        sel = 1'b0;
        cyc();
    endtask

    initial begin
        do_reset();
        check("rst_tempo", int'(tempo), 0);
        check("rst_saldo", int'(saldo), 0);
        // wrong login stays idle
        press(5'd31, 4'd0);
        check("bad_login_tempo", int'(tempo), 0);
        check("bad_login_saldo", int'(saldo), 0);
        // valid login: Tempo loads 300, then counts down
        do_reset();
        cod = 5'd16; pin = 4'd9; sel = 1'b1;
        cyc();
        check("login_tempo", int'(tempo), 300);
        check("login_saldo", int'(saldo), 10);
        sel = 1'b0;
        cyc();
        check("login_tempo_dec", int'(tempo), 299);
        // deposits: 10+3+1 = 14 accepted, 14+3 overflows
        txn(1'b0, 4'd3, 1'b1);
        check("dep_ok_saldo", int'(saldo), 14);
        check("dep_ok_cout", int'(cout), 0);
        txn(1'b0, 4'd3, 1'b0);
        check("dep_ovf_saldo", int'(saldo), 14);
        check("dep_ovf_cout", int'(cout), 1);
        // withdrawals from 10: -4 accepted, -8 borrows
        do_reset();
        press(5'd16, 4'd9);
        txn(1'b1, 4'd4, 1'b0);
        check("wd_ok_saldo", int'(saldo), 6);
        check("wd_ok_cout", int'(cout), 0);
        txn(1'b1, 4'd8, 1'b0);
        check("wd_brw_saldo", int'(saldo), 6);
        check("wd_brw_cout", int'(cout), 1);
        // timeout after 300 idle cycles, balance survives into the next session
        press(5'd16, 4'd9);
        for (int i = 0; i < 298; i++) cyc();
        check("to_tempo_last", int'(tempo), 1);
        cyc();
        check("to_tempo", int'(tempo), 0);
        check("to_saldo", int'(saldo), 0);
        press(5'd16, 4'd9);
        check("persist_saldo", int'(saldo), 6);
        // cancel code ends the session at once
        cod = 5'd31; sel = 1'b1;
        cyc();
        check("cancel_tempo", int'(tempo), 0);
        check("cancel_saldo", int'(saldo), 0);
        sel = 1'b0;
        cyc();
        // ENABLE=0 freezes the timer
        press(5'd16, 4'd9);
        en = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        check("freeze_tempo", int'(tempo), 299);
        en = 1'b1;
        cyc();
        // async reset mid-session
        reset = 1'b1;
        #1;
        check("areset_tempo", int'(tempo), 0);
        check("areset_saldo", int'(saldo), 0);
        do_reset();
        // three bad logins lock the teller; a valid login is then ignored
        press(5'd1, 4'd9);
        press(5'd16, 4'd0);
        press(5'd16, 4'd9);
        check("pre_lock_saldo", int'(saldo), 10);
        do_reset();
        for (int i = 0; i < 3; i++) press(5'd2, 4'd2);
        press(5'd16, 4'd9);
        check("locked_tempo", int'(tempo), 0);
        check("locked_saldo", int'(saldo), 0);
        // randomized traffic, periodic resets to escape lockout
        for (int i = 0; i < 3000; i++) begin
            int r;
            if (i % 300 == 0) do_reset();
            en  = ($urandom % 8) != 0;
            sel = ($urandom % 3) == 0;
            r   = $urandom % 4;
            cod = r == 0 ? 5'd16 : r == 1 ? 5'd31 : 5'($urandom);
            pin = ($urandom % 2) ? 4'd9 : 4'($urandom);
            val = 4'($urandom);
            cin = 1'($urandom);
            op  = 1'($urandom);
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
